// File: rtl/param_alu_pkg.sv
// Shared opcode and FSM state types plus reset values for the sequential ALU
// and the blocks that drive or decode it.
package param_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_NOT  = 3'b010,
    OP_ZERO = 3'b011,
    OP_SUB  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam state_e RST_STATE = S_IDLE;
  localparam op_e    RST_OP    = OP_ADD;
  localparam logic   RST_CF    = 1'b0;
  localparam logic   RST_Z     = 1'b1;
  localparam logic   RST_OV    = 1'b0;

  function automatic logic op_is_mul(input op_e op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/toggle_sync_edge.sv
// Multi-flop synchroniser for a slow asynchronous level (switch/button) with a
// single-cycle rising-edge pulse taken from the last sync flop.
module toggle_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/param_alu_seq.sv
// Triggered N-bit ALU with registered result/flags and an iterative shift-add
// multiplier. Optional signed-overflow flag OV when PARAM_ALU_OVF_EN is defined.
//
//   state  | meaning
//   S_IDLE | waiting for a trigger; operands latched on trigger
//   S_EXEC | single-cycle op computed and registered
//   S_MUL  | one shift-add step per cycle, WIDTH cycles
//   S_DONE | DONE pulse, result already on OUT
module param_alu_seq
  import param_alu_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [2:0]       CTRL,
  input  logic             TOGGLE,
  output logic [WIDTH-1:0] OUT,
  output logic             CF,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
`ifdef PARAM_ALU_OVF_EN
  ,
  output logic             OV
`endif
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam int                MSB      = WIDTH - 1;

  state_e               state_q, state_d;
  logic                 trig;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, mcand_q, mcand_d, prod_sum;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     out_q, out_d, alu_res;
  logic                 cf_q, cf_d, z_q, z_d, alu_cf;
  logic                 mul_last;
  logic [WIDTH:0]       sum_w, diff_w;
`ifdef PARAM_ALU_OVF_EN
  logic                 ov_q, ov_d, alu_ov, mul_ov;
  logic [WIDTH-1:0]     mul_hi_s;
`endif

  toggle_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_sys  (CLK),
    .rst_n    (RST_N),
    .async_in (TOGGLE),
    .rise     (trig)
  );

  assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (trig) state_d = op_is_mul(op_e'(CTRL)) ? S_MUL : S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_MUL:   if (mul_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_q != S_IDLE);
    DONE = (state_q == S_DONE);
  end

  always_comb begin
    sum_w   = {1'b0, a_q} + {1'b0, b_q};
    diff_w  = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_cf  = 1'b0;
    unique case (op_q)
      OP_ADD:  {alu_cf, alu_res} = sum_w;
      OP_AND:  alu_res = a_q & b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_ZERO: alu_res = '0;
      OP_SUB:  begin
        alu_res = diff_w[WIDTH-1:0];
        alu_cf  = diff_w[WIDTH];
      end
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

`ifdef PARAM_ALU_OVF_EN
  always_comb begin
    alu_ov = 1'b0;
    if (op_q == OP_ADD)
      alu_ov = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
    else if (op_q == OP_SUB)
      alu_ov = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
  end

  // Signed high half = unsigned high half minus each operand where the other is negative.
  always_comb begin
    mul_hi_s = prod_sum[2*WIDTH-1:WIDTH]
             - (a_q[MSB] ? b_q : '0)
             - (b_q[MSB] ? a_q : '0);
    mul_ov   = !(((mul_hi_s == '0) && !prod_sum[MSB]) ||
                 ((mul_hi_s == '1) &&  prod_sum[MSB]));
  end
`endif

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    cf_d     = cf_q;
    z_d      = z_q;
`ifdef PARAM_ALU_OVF_EN
    ov_d     = ov_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          op_d     = op_e'(CTRL);
          a_d      = IN1;
          b_d      = IN2;
          prod_d   = '0;
          mcand_d  = {{WIDTH{1'b0}}, IN1};
          mplier_d = IN2;
          cnt_d    = '0;
        end
      end
      S_EXEC: begin
        out_d = alu_res;
        cf_d  = alu_cf;
        z_d   = (alu_res == '0);
`ifdef PARAM_ALU_OVF_EN
        ov_d  = alu_ov;
`endif
      end
      S_MUL: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mul_last) begin
          out_d = prod_sum[WIDTH-1:0];
          cf_d  = |prod_sum[2*WIDTH-1:WIDTH];
          z_d   = (prod_sum[WIDTH-1:0] == '0);
`ifdef PARAM_ALU_OVF_EN
          ov_d  = mul_ov;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q     <= RST_OP;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      cf_q     <= RST_CF;
      z_q      <= RST_Z;
`ifdef PARAM_ALU_OVF_EN
      ov_q     <= RST_OV;
`endif
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      cf_q     <= cf_d;
      z_q      <= z_d;
`ifdef PARAM_ALU_OVF_EN
      ov_q     <= ov_d;
`endif
    end
  end

  assign OUT = out_q;
  assign CF  = cf_q;
  assign Z   = z_q;
`ifdef PARAM_ALU_OVF_EN
  assign OV  = ov_q;
`endif

endmodule

// File: tb/tb_param_alu_seq.sv
// Bench for param_alu_seq (WIDTH=4): arithmetic reference model with per-cycle
// compare, directed operation vectors, trigger-handling and reset-abort cases.
module tb_param_alu_seq;
  localparam int W = 4;
  localparam int S = 2;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [W-1:0] IN1 = '0;
  logic [W-1:0] IN2 = '0;
  logic [2:0]   CTRL = '0;
  logic         TOGGLE = 1'b0;
  logic [W-1:0] OUT;
  logic         CF, Z, BUSY, DONE;
`ifdef PARAM_ALU_OVF_EN
  logic         OV;
`endif

  int chk = 0;
  int err = 0;

  param_alu_seq #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .IN1    (IN1),
    .IN2    (IN2),
    .CTRL   (CTRL),
    .TOGGLE (TOGGLE),
    .OUT    (OUT),
    .CF     (CF),
    .Z      (Z),
    .BUSY   (BUSY),
    .DONE   (DONE)
`ifdef PARAM_ALU_OVF_EN
    ,
    .OV     (OV)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act != exp) begin
      err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {ov, cf, out}, computed with plain integer arithmetic.
  function automatic logic [W+1:0] model_alu(input int op, input int a, input int b);
    int m, r, sa, sb, sr, lo, slo;
    logic cf, ov;
    m  = 1 << W;
    sa = (a >= m/2) ? a - m : a;
    sb = (b >= m/2) ? b - m : b;
    cf = 1'b0;
    ov = 1'b0;
    case (op)
      0: begin r = a + b; cf = (r >= m); sr = sa + sb; ov = (sr > m/2 - 1) || (sr < -m/2); end
      1: r = a & b;
      2: r = ~a;
      3: r = 0;
      4: begin r = a - b; cf = (a < b); sr = sa - sb; ov = (sr > m/2 - 1) || (sr < -m/2); end
      5: r = a | b;
      6: r = a ^ b;
      default: begin
        r   = a * b;
        cf  = (r >= m);
        sr  = sa * sb;
        lo  = r % m;
        slo = (lo >= m/2) ? lo - m : lo;
        ov  = (slo != sr);
      end
    endcase
    r = r & (m - 1);
    return {ov, cf, r[W-1:0]};
  endfunction

  // Reference: trigger appears S samples after TOGGLE rises; busy for 2 or W+1 cycles.
  logic         hist [0:S];
  int           m_left = 0;
  logic [W-1:0] m_out = '0;
  logic         m_cf = 1'b0, m_z = 1'b1, m_ov = 1'b0;
  logic [W+1:0] m_res = '0;
  logic         m_rise;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k <= S; k++) hist[k] = 1'b0;
      m_left = 0;
      m_out  = '0;
      m_cf   = 1'b0;
      m_z    = 1'b1;
      m_ov   = 1'b0;
    end else begin
      m_rise = hist[S-1] && !hist[S];
      if (m_left == 0) begin
        if (m_rise) begin
          m_res  = model_alu(int'(CTRL), int'(IN1), int'(IN2));
          m_left = (CTRL == 3'd7) ? W + 1 : 2;
        end
      end else begin
        m_left--;
        if (m_left == 1) begin
          m_out = m_res[W-1:0];
          m_cf  = m_res[W];
          m_ov  = m_res[W+1];
          m_z   = (m_res[W-1:0] == '0);
        end
      end
      for (int k = S; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = TOGGLE;
    end
  end

  always @(negedge CLK) begin
    check("cyc_busy", int'(BUSY), int'(m_left != 0));
    check("cyc_done", int'(DONE), int'(m_left == 1));
    check("cyc_out",  int'(OUT),  int'(m_out));
    check("cyc_cf",   int'(CF),   int'(m_cf));
    check("cyc_z",    int'(Z),    int'(m_z));
`ifdef PARAM_ALU_OVF_EN
    check("cyc_ov",   int'(OV),   int'(m_ov));
`endif
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, out;
    logic         cf, z, ov;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] out, input logic cf, input logic z,
                         input logic ov, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.out = out; v.cf = cf; v.z = z; v.ov = ov; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Counts DONE pulses over n cycles, sampled at negedge.
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (DONE) cnt++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [W+1:0] mr;
    int n, busy_n;
    bit got;
    mr = model_alu(int'(v.op), int'(v.a), int'(v.b));
    check("model_out", int'(mr[W-1:0]), int'(v.out));
    check("model_cf",  int'(mr[W]),     int'(v.cf));
`ifdef PARAM_ALU_OVF_EN
    check("model_ov",  int'(mr[W+1]),   int'(v.ov));
`endif
    IN1 = v.a; IN2 = v.b; CTRL = v.op; TOGGLE = 1'b1;
    n = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      if (n == 3) begin
        IN1  = W'($urandom);
        IN2  = W'($urandom);
        CTRL = 3'($urandom_range(0, 7));
      end
      if (BUSY) busy_n++;
      if (DONE) got = 1'b1;
    end
    check("latency",     n,         v.lat);
    check("busy_cycles", busy_n,    v.lat - 2);
    check("vec_out",     int'(OUT), int'(v.out));
    check("vec_cf",      int'(CF),  int'(v.cf));
    check("vec_z",       int'(Z),   int'(v.z));
`ifdef PARAM_ALU_OVF_EN
    check("vec_ov",      int'(OV),  int'(v.ov));
`endif
    TOGGLE = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Latency counted from the negedge TOGGLE rises: S sync cycles + 2, or S + W + 1 for MUL.
    add_vec(3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4);
    add_vec(3'b000, 4'b1100, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0, 4);
    add_vec(3'b100, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0, 4);
    add_vec(3'b100, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0, 4);
    add_vec(3'b010, 4'b1001, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0, 4);
    add_vec(3'b011, 4'b0111, 4'b0011, 4'b0000, 1'b0, 1'b1, 1'b0, 4);
    add_vec(3'b111, 4'b0101, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b1, 7);
    add_vec(3'b111, 4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 7);
    add_vec(3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1, 4);
    add_vec(3'b100, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1, 4);
    add_vec(3'b001, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0, 4);
    add_vec(3'b101, 4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0, 4);
    add_vec(3'b110, 4'b1111, 4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0, 4);

    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_out",  int'(OUT),  0);
    check("rst_z",    int'(Z),    1);
    check("rst_cf",   int'(CF),   0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    RST_N = 1'b1;
    count_done(4, c);
    check("idle_no_done", c, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Retrigger pulse during MUL is dropped.
    IN1 = 4'd5; IN2 = 4'd3; CTRL = 3'b111; TOGGLE = 1'b1;
    repeat (3) @(negedge CLK);
    TOGGLE = 1'b0;
    @(negedge CLK);
    TOGGLE = 1'b1;
    repeat (2) @(negedge CLK);
    TOGGLE = 1'b0;
    count_done(14, c);
    check("mul_retrig_dones", c, 1);

    // Held-high TOGGLE yields one operation.
    IN1 = 4'd2; IN2 = 4'd3; CTRL = 3'b000; TOGGLE = 1'b1;
    count_done(50, c);
    TOGGLE = 1'b0;
    begin
      int c2;
      count_done(6, c2);
      check("hold_high_dones", c + c2, 1);
    end
    check("hold_high_out", int'(OUT), 5);

    // Glitch between edges: may be missed, never doubled.
    @(negedge CLK);
    #1 TOGGLE = 1'b1;
    #2 TOGGLE = 1'b0;
    count_done(10, c);
    check("glitch_short_le1", int'(c <= 1), 1);

    // Glitch straddling a rising edge: still at most one trigger.
    @(negedge CLK);
    #3 TOGGLE = 1'b1;
    #4 TOGGLE = 1'b0;
    count_done(10, c);
    check("glitch_edge_le1", int'(c <= 1), 1);

    // Reset mid-MUL aborts at once with no DONE.
    IN1 = 4'hF; IN2 = 4'hF; CTRL = 3'b111; TOGGLE = 1'b1;
    repeat (4) @(negedge CLK);
    check("pre_rst_busy", int'(BUSY), 1);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("abort_out",  int'(OUT),  0);
    check("abort_z",    int'(Z),    1);
    check("abort_cf",   int'(CF),   0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_done", int'(DONE), 0);
    TOGGLE = 1'b0;
    count_done(5, c);
    check("abort_dones_in_rst", c, 0);
    RST_N = 1'b1;
    count_done(8, c);
    check("abort_dones_after", c, 0);

    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
